// File: rtl/connect4_input_conditioner.sv
// Pin front end: per-channel 2-FF synchroniser, counter debouncer and press pulse,
// plus confirm-triggered one-hot column decode. Define HOLD_REPEAT_EN for hold-to-repeat pulses.
module connect4_input_conditioner #(
    parameter int unsigned NUM_CH        = 12,
    parameter int unsigned COLS          = 7,
    parameter int unsigned CONFIRM_IDX   = 7,
    parameter int unsigned DB_CYCLES     = 4,
    parameter int unsigned REPEAT_CYCLES = 1000
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       io_in,
    output logic [NUM_CH-1:0]       btn_level,
    output logic [NUM_CH-1:0]       btn_pulse,
    output logic                    move_valid,
    output logic [$clog2(COLS)-1:0] move_col,
    output logic                    move_err
);

    localparam int unsigned CW   = $clog2(DB_CYCLES + 1);
    localparam int unsigned COLW = $clog2(COLS);

    logic [NUM_CH-1:0] sync1_q, sync2_q;
    logic [NUM_CH-1:0] level_q, level_d;
    logic [NUM_CH-1:0] pulse_q, pulse_d;
    logic [CW-1:0]     cnt_q [NUM_CH];
    logic [CW-1:0]     cnt_d [NUM_CH];
    logic              valid_q, valid_d;
    logic              err_q, err_d;
    logic [COLW-1:0]   col_q, col_d;

`ifdef HOLD_REPEAT_EN
    localparam int unsigned RW = $clog2(REPEAT_CYCLES + 1);
    logic [RW-1:0] rpt_q [NUM_CH];
    logic [RW-1:0] rpt_d [NUM_CH];
`endif

    always_comb begin
        level_d = level_q;
        pulse_d = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] == level_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CW'(DB_CYCLES - 1)) begin
                level_d[i] = sync2_q[i];
                cnt_d[i]   = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
            pulse_d[i] = level_d[i] & ~level_q[i];
`ifdef HOLD_REPEAT_EN
            // Repeat count runs only while the level stays high; the confirm channel never repeats.
            rpt_d[i] = '0;
            if (i != CONFIRM_IDX && level_q[i] && level_d[i]) begin
                if (rpt_q[i] == RW'(REPEAT_CYCLES - 1)) begin
                    pulse_d[i] = 1'b1;
                end else begin
                    rpt_d[i] = rpt_q[i] + RW'(1);
                end
            end
`endif
        end
    end

    // Decode sees the levels already registered alongside the confirm pulse.
    always_comb begin
        int unsigned     hits;
        logic [COLW-1:0] idx;
        hits    = 0;
        idx     = '0;
        valid_d = 1'b0;
        err_d   = 1'b0;
        col_d   = col_q;
        for (int unsigned i = 0; i < COLS; i++) begin
            if (level_q[i]) begin
                hits = hits + 1;
                idx  = COLW'(i);
            end
        end
        if (pulse_q[CONFIRM_IDX]) begin
            if (hits == 1) begin
                valid_d = 1'b1;
                col_d   = idx;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            level_q <= '0;
            pulse_q <= '0;
            cnt_q   <= '{default: '0};
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            col_q   <= '0;
`ifdef HOLD_REPEAT_EN
            rpt_q   <= '{default: '0};
`endif
        end else begin
            sync1_q <= io_in;
            sync2_q <= sync1_q;
            level_q <= level_d;
            pulse_q <= pulse_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            col_q   <= col_d;
`ifdef HOLD_REPEAT_EN
            rpt_q   <= rpt_d;
`endif
        end
    end

    assign btn_level  = level_q;
    assign btn_pulse  = pulse_q;
    assign move_valid = valid_q;
    assign move_err   = err_q;
    assign move_col   = col_q;

endmodule

// File: tb/tb_connect4_input_conditioner.sv
// Bench for connect4_input_conditioner: directed scenarios plus randomized button traffic
// checked every cycle against a history-window reference model.
module tb_connect4_input_conditioner;

    localparam int unsigned NUM_CH = 12;
    localparam int unsigned COLS   = 7;
    localparam int unsigned CONF   = 7;
    localparam int unsigned DB     = 4;
    localparam int unsigned RPT    = 10;

    logic              clock = 1'b0;
    logic              reset;
    logic [NUM_CH-1:0] io_in;
    logic [NUM_CH-1:0] btn_level, btn_pulse;
    logic              move_valid, move_err;
    logic [2:0]        move_col;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    connect4_input_conditioner #(
        .NUM_CH(NUM_CH), .COLS(COLS), .CONFIRM_IDX(CONF),
        .DB_CYCLES(DB), .REPEAT_CYCLES(RPT)
    ) dut (
        .clock(clock), .reset(reset), .io_in(io_in),
        .btn_level(btn_level), .btn_pulse(btn_pulse),
        .move_valid(move_valid), .move_col(move_col), .move_err(move_err)
    );

    always #5 clock = ~clock;

    // Reference: a level flips once the last DB synchronised samples all disagree with it.
    logic [NUM_CH-1:0] hist [$];
    logic [NUM_CH-1:0] m_lev = '0, m_pulse = '0;
    logic              m_valid = 1'b0, m_err = 1'b0;
    logic [2:0]        m_col = '0;
    int unsigned       edge_n = 0;
    int unsigned       rise_at [NUM_CH];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned ones(input logic [COLS-1:0] v);
        int unsigned c = 0;
        for (int unsigned i = 0; i < COLS; i++) c += v[i];
        return c;
    endfunction

    task automatic model_edge(input logic [NUM_CH-1:0] x, input logic rst);
        logic [NUM_CH-1:0] np, e;
        logic              all_diff;
        int unsigned       held;
        edge_n++;
        if (rst) begin
            hist.delete();
            m_lev = '0; m_pulse = '0; m_valid = 1'b0; m_err = 1'b0; m_col = '0;
            return;
        end
        held    = ones(m_lev[COLS-1:0]);
        m_valid = m_pulse[CONF] && held == 1;
        m_err   = m_pulse[CONF] && held != 1;
        if (m_valid)
            for (int unsigned c = 0; c < COLS; c++) if (m_lev[c]) m_col = 3'(c);
        hist.push_back(x);
        if (hist.size() > DB + 2) void'(hist.pop_front());
        np = '0;
        for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
            all_diff = (hist.size() == DB + 2);
            for (int unsigned k = 0; k < DB && all_diff; k++) begin
                e = hist[k];
                if (e[ch] == m_lev[ch]) all_diff = 1'b0;
            end
            if (all_diff) begin
                m_lev[ch] = ~m_lev[ch];
                if (m_lev[ch]) begin
                    np[ch] = 1'b1;
                    rise_at[ch] = edge_n;
                end
            end
`ifdef HOLD_REPEAT_EN
            else if (ch != CONF && m_lev[ch] && ((edge_n - rise_at[ch]) % RPT) == 0) begin
                np[ch] = 1'b1;
            end
`endif
        end
        m_pulse = np;
    endtask

    task automatic tick(input logic [NUM_CH-1:0] x, input logic rst);
        io_in = x;
        reset = rst;
        @(posedge clock);
        model_edge(x, rst);
        @(negedge clock);
        chk("btn_level", 32'(btn_level), 32'(m_lev));
        chk("btn_pulse", 32'(btn_pulse), 32'(m_pulse));
        chk("move_valid", 32'(move_valid), 32'(m_valid));
        chk("move_err", 32'(move_err), 32'(m_err));
        chk("move_col", 32'(move_col), 32'(m_col));
    endtask

    initial begin
        int unsigned first, cnt_v, cnt_e, col_seen, cnt_p;
        logic [NUM_CH-1:0] pat;

        tick('0, 1'b1);
        tick('0, 1'b1);
        chk("reset_outputs", 32'({btn_level, btn_pulse, move_valid, move_err, move_col}), 32'd0);
        repeat (3) tick('0, 1'b0);

        // Clean press on channel 3.
        first = 0;
        for (int i = 1; i <= 12; i++) begin
            tick(12'h008, 1'b0);
            if (btn_pulse[3] && first == 0) first = i;
        end
        chk("press_latency", first, 6);
        repeat (10) tick('0, 1'b0);

        // Three-cycle glitch on channel 5.
        cnt_p = 0;
        repeat (3) begin tick(12'h020, 1'b0); cnt_p += btn_level[5] + btn_pulse[5]; end
        repeat (10) begin tick('0, 1'b0); cnt_p += btn_level[5] + btn_pulse[5]; end
        chk("glitch_activity", cnt_p, 0);

        // Legal move on column 2.
        repeat (8) tick(12'h004, 1'b0);
        cnt_v = 0; cnt_e = 0; col_seen = 7;
        repeat (12) begin
            tick(12'h084, 1'b0);
            cnt_v += move_valid; cnt_e += move_err;
            if (move_valid) col_seen = move_col;
        end
        chk("legal_valid_cnt", cnt_v, 1);
        chk("legal_err_cnt", cnt_e, 0);
        chk("legal_col", col_seen, 2);
        repeat (10) tick('0, 1'b0);

        // Two columns held.
        repeat (8) tick(12'h012, 1'b0);
        cnt_v = 0; cnt_e = 0;
        repeat (12) begin tick(12'h092, 1'b0); cnt_v += move_valid; cnt_e += move_err; end
        chk("two_col_err_cnt", cnt_e, 1);
        chk("two_col_valid_cnt", cnt_v, 0);
        chk("two_col_col_held", 32'(move_col), 2);
        repeat (10) tick('0, 1'b0);

        // No column held.
        cnt_v = 0; cnt_e = 0;
        repeat (12) begin tick(12'h080, 1'b0); cnt_v += move_valid; cnt_e += move_err; end
        chk("no_col_err_cnt", cnt_e, 1);
        chk("no_col_valid_cnt", cnt_v, 0);
        repeat (10) tick('0, 1'b0);

        // Reset in the middle of a debounce with channel 0 held.
        repeat (4) tick(12'h001, 1'b0);
        repeat (2) begin
            tick(12'h001, 1'b1);
            chk("mid_reset_outputs", 32'({btn_level, btn_pulse, move_valid, move_err, move_col}), 32'd0);
        end
        first = 0;
        for (int i = 1; i <= 12; i++) begin
            tick(12'h001, 1'b0);
            if (btn_pulse[0] && first == 0) first = i;
        end
        chk("restart_latency", first, 6);
        repeat (10) tick('0, 1'b0);

`ifdef HOLD_REPEAT_EN
        // Hold channel 6 for 35 cycles beyond its first pulse.
        cnt_p = 0;
        for (int i = 0; i < 20 && cnt_p == 0; i++) begin
            tick(12'h040, 1'b0);
            cnt_p += btn_pulse[6];
        end
        repeat (35) begin tick(12'h040, 1'b0); cnt_p += btn_pulse[6]; end
        chk("repeat_pulses", cnt_p, 4);
        repeat (20) tick('0, 1'b0);

        // Holding confirm must not repeat the move.
        repeat (8) tick(12'h004, 1'b0);
        cnt_v = 0;
        repeat (60) begin tick(12'h084, 1'b0); cnt_v += move_valid; end
        chk("confirm_hold_valid", cnt_v, 1);
        repeat (10) tick('0, 1'b0);
`endif

        // Randomized traffic.
        for (int s = 0; s < 400; s++) begin
            case ($urandom_range(0, 3))
                0:       pat = NUM_CH'($urandom);
                1:       pat = (NUM_CH'(1) << $urandom_range(0, COLS - 1)) | ($urandom_range(0, 1) ? 12'h080 : 12'h000);
                2:       pat = '0;
                default: pat = NUM_CH'(1) << $urandom_range(0, NUM_CH - 1);
            endcase
            if ($urandom_range(0, 39) == 0) begin
                repeat ($urandom_range(1, 2)) tick(pat, 1'b1);
            end
            repeat ($urandom_range(1, 12)) tick(pat, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
